// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - funct3 encodings for RV64 loads/stores (F3_B .. F3_WU)
//   - responder FSM state enum
//   - latched request struct
//   - helpers: access size, byte mask, funct3 legality
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  funct3;
    } req_t;

    // Access size in bytes; only the low two funct3 bits carry size.
    function automatic logic [3:0] size_from_funct3(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Byte-enable pattern for lane 0; shifted up by the byte lane later.
    function automatic logic [7:0] byte_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // 111 is never legal; unsigned variants only exist for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic write);
        return (f3 == 3'b111) || (write && f3[2]);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one 64-bit word.
//   Store side: byte_en / wdata_sh place right-aligned store data at the lane.
//   Load side : rdata_ext shifts the word down by the lane and sign- or
//               zero-extends according to funct3.
// Ports:
//   funct3    in  3   size/sign field
//   lane      in  3   byte offset within the word (addr[2:0])
//   wdata     in  64  right-aligned store data
//   rword     in  64  raw word read from storage
//   byte_en   out 8   bytes of the word touched by a store
//   wdata_sh  out 64  store data moved to its lane
//   rdata_ext out 64  extended load result
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  lane,
    input  logic [63:0] wdata,
    input  logic [63:0] rword,
    output logic [7:0]  byte_en,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext
);

    logic [5:0]  bit_sh;
    logic [63:0] rsh;
    logic        sext;

    assign bit_sh   = {lane, 3'b000};
    assign byte_en  = byte_mask(funct3[1:0]) << lane;
    assign wdata_sh = wdata << bit_sh;
    assign rsh      = rword >> bit_sh;
    assign sext     = ~funct3[2];

    always_comb begin
        rdata_ext = rsh;
        case (funct3[1:0])
            2'b00:   rdata_ext = {{56{sext & rsh[7]}},  rsh[7:0]};
            2'b01:   rdata_ext = {{48{sext & rsh[15]}}, rsh[15:0]};
            2'b10:   rdata_ext = {{32{sext & rsh[31]}}, rsh[31:0]};
            default: rdata_ext = rsh;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder for the core's
// data port, with a fixed response latency and valid/ready on both sides.
// Parameters:
//   DEPTH_WORDS  number of 64-bit storage words (power of two, >= 2)
//   LATENCY      cycles from request acceptance to response (>= 1)
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_write                 1 = store, 0 = load
//   req_addr, req_wdata       byte address, right-aligned store data
//   req_funct3                RV64 size/sign field
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_err        extended load data (0 on store/error), error flag
// With acceptance on edge T, the response is presented from edge
// T+LATENCY-1 onward, so it is seen valid LATENCY cycles after acceptance;
// one request completes every LATENCY+1 cycles at best.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    req_t            req_q;
    req_t            cur;

    logic [63:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic [3:0]      size;
    logic            misal;
    logic            oor;
    logic            err;
    logic            enter_resp;
    logic            commit;
    logic            mem_we;
    logic [7:0]      byte_en;
    logic [63:0]     wdata_sh;
    logic [63:0]     rdata_ext;
    logic [63:0]     rsp_data_d;

    // With LATENCY=1 the response is formed on the acceptance edge, so the
    // live request inputs stand in for the latch while idle.
    always_comb begin
        cur = req_q;
        if (state == ST_IDLE) begin
            cur.write  = req_write;
            cur.addr   = req_addr;
            cur.wdata  = req_wdata;
            cur.funct3 = req_funct3;
        end
    end

    assign idx   = cur.addr[3 +: AW];
    assign size  = size_from_funct3(cur.funct3[1:0]);
    assign misal = (cur.addr[2:0] & 3'(size - 4'd1)) != 3'b000;
    assign oor   = cur.addr[63:AW+3] != '0;
    assign err   = misal | oor | f3_illegal(cur.funct3, cur.write);

    assign enter_resp = (state == ST_IDLE && req_valid && LATENCY == 1) ||
                        (state == ST_WAIT && cnt == CW'(1));
    assign commit     = enter_resp & cur.write & ~err;
    // While rst is held the FSM sits in IDLE and accepts nothing, so a
    // request presented during reset must not reach the array either.
    assign mem_we     = commit & ~rst;

    dmem_lane_align u_align (
        .funct3    (cur.funct3),
        .lane      (cur.addr[2:0]),
        .wdata     (cur.wdata),
        .rword     (mem[idx]),
        .byte_en   (byte_en),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    assign rsp_data_d = (err || cur.write) ? 64'd0 : rdata_ext;

    // Storage is not reset; byte-granular read-modify-write of the word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q     <= cur;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_data_d;
                            rsp_err   <= err;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == CW'(1)) begin
                        state     <= ST_RESP;
                        cnt       <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rsp_data_d;
                        rsp_err   <= err;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DW  = 256;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    logic        req_valid_1, req_ready_1, req_write_1;
    logic [63:0] req_addr_1, req_wdata_1;
    logic [2:0]  req_funct3_1;
    logic        rsp_valid_1, rsp_ready_1, rsp_err_1;
    logic [63:0] rsp_rdata_1;

    dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_write(req_write_1),
        .req_addr(req_addr_1), .req_wdata(req_wdata_1), .req_funct3(req_funct3_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the LATENCY=2 responder --------
    logic [63:0] m_mem [DW];
    logic        m_busy = 1'b0;
    int          m_age  = 0;
    logic        m_w;
    logic [63:0] m_a, m_d;
    logic [2:0]  m_f;
    logic [63:0] m_rdata = '0;
    logic        m_err   = 1'b0;

    // Executes the latched request against the model memory, byte by byte.
    task automatic model_exec();
        int sz, idx, off;
        logic [63:0] v;
        sz      = 1 << m_f[1:0];
        m_err   = (m_f == 3'b111) || (m_w && m_f[2]) ||
                  (m_a >= 64'(DW * 8)) || ((m_a % sz) != 0);
        m_rdata = '0;
        if (!m_err) begin
            idx = int'(m_a / 8);
            off = int'(m_a % 8);
            if (m_w) begin
                for (int b = 0; b < sz; b++) m_mem[idx][8*(off+b) +: 8] = m_d[8*b +: 8];
            end else begin
                v = '0;
                for (int b = 0; b < sz; b++) v[8*b +: 8] = m_mem[idx][8*(off+b) +: 8];
                if (!m_f[2] && sz < 8 && v[8*sz-1])
                    for (int k = 8*sz; k < 64; k++) v[k] = 1'b1;
                m_rdata = v;
            end
        end
    endtask

    // m_age counts edges since acceptance; the response is due once it
    // reaches LAT-1 and leaves on the first edge after that with rsp_ready.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
        end else if (m_busy) begin
            if (m_age >= LAT - 1 && rsp_ready) begin
                m_busy = 1'b0;
            end else if (m_age < LAT - 1) begin
                m_age++;
                if (m_age == LAT - 1) model_exec();
            end
        end else if (req_valid) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_w = req_write; m_a = req_addr; m_d = req_wdata; m_f = req_funct3;
            if (LAT == 1) model_exec();
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'd1);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_rdata", rsp_rdata, 64'd0);
            chk("rst_rsp_err",   64'(rsp_err), 64'd0);
        end else begin
            chk("req_ready", 64'(req_ready), 64'(!m_busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_age >= LAT - 1));
            if (m_busy && m_age >= LAT - 1) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err",   64'(rsp_err), 64'(m_err));
            end
        end
    end

    // ---------------- LATENCY=1 instance monitor --------------------------
    logic [63:0] exp_q1[$];
    int n_rsp1 = 0;
    int last_cyc1 = 0;
    always @(negedge clk) begin
        if (!rst && rsp_valid_1) begin
            if (exp_q1.size() == 0) begin
                chk("l1_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                chk("l1_rdata", rsp_rdata_1, exp_q1.pop_front());
                chk("l1_err", 64'(rsp_err_1), 64'd0);
            end
            if (n_rsp1 > 0) chk("l1_gap", 64'(cyc - last_cyc1), 64'd2);
            last_cyc1 = cyc;
            n_rsp1++;
        end
    end

    // ---------------- driver ----------------------------------------------
    // Called just after a negedge; returns just after a negedge.
    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [2:0] f, input int hold,
                          output int lat, output logic [63:0] rd, output logic er);
        int n;
        lat = 0; rd = '0; er = 1'b0;
        req_write = w; req_addr = a; req_wdata = d; req_funct3 = f; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("accept_timeout", 64'd1, 64'd0);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin
            chk("rsp_timeout", 64'd1, 64'd0);
            return;
        end
        rd = rsp_rdata; er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ready_after_rsp", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [63:0] rd;
        logic er;
        logic w;
        logic [2:0] f;
        logic [63:0] a, d;
        int sz, r, n;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        rsp_ready = 1'b0;
        req_valid_1 = 1'b0; req_write_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0;
        req_funct3_1 = '0; rsp_ready_1 = 1'b1;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_rsp_err",   64'(rsp_err), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Give every word a defined value (word 4 = 0x20 is pinned).
        for (int i = 0; i < DW; i++) begin
            d = (i == 4) ? 64'hCAFEF00D_12345678 : {$urandom, $urandom};
            do_req(1'b1, 64'(i * 8), d, F3_D, 0, lat, rd, er);
        end

        // Directed sequence with hand-computed expectations.
        do_req(1'b1, 64'h10, 64'h1122334455667788, F3_D, 0, lat, rd, er);
        chk("sd_err", 64'(er), 64'd0);
        do_req(1'b0, 64'h10, '0, F3_D, 0, lat, rd, er);
        chk("ld_latency", 64'(lat), 64'd2);
        chk("ld_rdata", rd, 64'h1122334455667788);
        chk("ld_err", 64'(er), 64'd0);
        do_req(1'b0, 64'h17, '0, F3_B, 0, lat, rd, er);
        chk("lb_17", rd, 64'h0000000000000011);
        do_req(1'b1, 64'h13, 64'h80, F3_B, 0, lat, rd, er);
        chk("sb_13_err", 64'(er), 64'd0);
        do_req(1'b0, 64'h13, '0, F3_B, 0, lat, rd, er);
        chk("lb_13", rd, 64'hFFFFFFFFFFFFFF80);
        do_req(1'b0, 64'h13, '0, F3_BU, 0, lat, rd, er);
        chk("lbu_13", rd, 64'h80);
        do_req(1'b0, 64'h16, '0, F3_HU, 0, lat, rd, er);
        chk("lhu_16", rd, 64'h1122);
        do_req(1'b0, 64'h12, '0, F3_W, 0, lat, rd, er);
        chk("lw_12_err", 64'(er), 64'd1);
        chk("lw_12_rdata", rd, 64'd0);
        do_req(1'b1, 64'h11, 64'hFFFF, F3_H, 0, lat, rd, er);
        chk("sh_11_err", 64'(er), 64'd1);
        do_req(1'b0, 64'h10, '0, F3_D, 0, lat, rd, er);
        chk("word10_unchanged", rd, 64'h1122334480667788);
        do_req(1'b0, 64'h800, '0, F3_D, 0, lat, rd, er);
        chk("ld_800_err", 64'(er), 64'd1);
        chk("ld_800_rdata", rd, 64'd0);
        do_req(1'b1, 64'h10, 64'h1, F3_BU, 0, lat, rd, er);
        chk("sbu_illegal", 64'(er), 64'd1);

        // Backpressure: response held for 5 cycles.
        do_req(1'b0, 64'h10, '0, F3_D, 5, lat, rd, er);
        chk("bp_rdata", rd, 64'h1122334480667788);

        // Reset while a store sits in the wait state.
        req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hDEADBEEF;
        req_funct3 = F3_W; req_valid = 1'b1;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_req_ready", 64'(req_ready), 64'd1);
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("async_rst_rsp_err",   64'(rsp_err), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_req(1'b0, 64'h20, '0, F3_WU, 0, lat, rd, er);
        chk("lwu_20_old", rd, 64'h12345678);

        // Randomised traffic; the compare process checks every cycle.
        for (int i = 0; i < 200; i++) begin
            f  = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            sz = 1 << f[1:0];
            r  = $urandom_range(0, 9);
            if (r == 0)      a = 64'(DW * 8) + 64'($urandom_range(0, 4096));
            else if (r == 1) a = {$urandom, $urandom};
            else             a = 64'($urandom_range(0, DW * 8 - 1));
            if ($urandom_range(0, 1) == 1) a = a & ~(64'(sz) - 64'd1);
            d = {$urandom, $urandom};
            do_req(w, a, d, f, $urandom_range(0, 3), lat, rd, er);
        end

        // LATENCY=1 instance: back-to-back stream with rsp_ready held high.
        for (int k = 0; k < 16; k++) begin
            if (k < 8) begin
                req_write_1 = 1'b1; req_addr_1 = 64'(k * 8);
                req_wdata_1 = 64'hF0E1D2C3B4A59687 + 64'(k); req_funct3_1 = F3_D;
            end else if (k < 12) begin
                req_write_1 = 1'b0; req_addr_1 = 64'((k - 8) * 8);
                req_wdata_1 = '0; req_funct3_1 = F3_D;
            end else begin
                req_write_1 = 1'b0; req_addr_1 = 64'((k - 8) * 8 + 7);
                req_wdata_1 = '0; req_funct3_1 = F3_B;
            end
            req_valid_1 = 1'b1;
            n = 0;
            while (!req_ready_1 && n < 10) begin @(negedge clk); n++; end
            if (!req_ready_1) chk("l1_accept_timeout", 64'd1, 64'd0);
            if (k < 8)       exp_q1.push_back(64'd0);
            else if (k < 12) exp_q1.push_back(64'hF0E1D2C3B4A59687 + 64'(k - 8));
            else             exp_q1.push_back(64'hFFFFFFFFFFFFFFF0);
            @(negedge clk);
        end
        req_valid_1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("l1_rsp_count", 64'(n_rsp1), 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
